// File: rtl/spi_pkg.sv
// Shared SPI link definitions: FSM state encoding, bus mode and default word size.
// Used by both the master and the slave ends of the link.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETUP    = 2'd1,
        TRANSFER = 2'd2,
        HOLD     = 2'd3
    } spi_state_t;

    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b0;

    localparam int DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/spi_clk_div.sv
// Free-running divider producing a one-cycle tick every CLK_DIV sclk cycles while enabled.
// The count is held at zero whenever the enable is low, so the first tick lands CLK_DIV cycles after enable rises.
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic sclk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge sclk) begin
        if (!reset || !en) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/spi_master_tx.sv
// Mode-0 SPI master: one full-duplex DATA_WIDTH-bit word per accepted start, MSB first,
// with a CLK_DIV-cycle select setup before the first edge and a CLK_DIV-cycle hold after the last.
module spi_master_tx
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CLK_DIV    = 4
) (
    input  logic                  sclk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  miso,
    output logic                  spi_clk,
    output logic                  mosi,
    output logic                  slave_select,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  busy,
    output logic                  done
);

    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("spi_master_tx: CLK_DIV must be at least 2");
    end
    if (CPOL != 1'b0 || CPHA != 1'b0) begin : g_bad_mode
        $error("spi_master_tx: only SPI mode 0 is implemented");
    end

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    spi_state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic [BW-1:0]         bit_cnt;
    logic                  tick;
    logic                  rise_tick;
    logic                  fall_tick;

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .sclk  (sclk),
        .reset (reset),
        .en    (state != IDLE),
        .tick  (tick)
    );

    // The SETUP-ending tick is also the first rising edge, so it samples like any other rise.
    assign rise_tick = tick && !spi_clk && (state == SETUP || state == TRANSFER);
    assign fall_tick = tick &&  spi_clk && (state == TRANSFER);

    always_ff @(posedge sclk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = SETUP;
            SETUP:    if (tick) state_nxt = TRANSFER;
            TRANSFER: if (fall_tick && bit_cnt == LAST_BIT) state_nxt = HOLD;
            HOLD:     if (tick) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (!reset) begin
            tx_shift <= '0;
            rx_shift <= '0;
            bit_cnt  <= '0;
            spi_clk  <= CPOL;
            rx_data  <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE && start) begin
                tx_shift <= tx_data;
                bit_cnt  <= '0;
            end
            if (state == HOLD && tick) begin
                done    <= 1'b1;
                rx_data <= rx_shift;
            end
            if (rise_tick) begin
                spi_clk  <= 1'b1;
                rx_shift <= {rx_shift[DATA_WIDTH-2:0], miso};
            end
            // The last falling edge leaves bit 0 on mosi through HOLD instead of shifting it out.
            if (fall_tick) begin
                spi_clk <= 1'b0;
                if (bit_cnt != LAST_BIT) begin
                    tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                    bit_cnt  <= bit_cnt + 1'b1;
                end
            end
        end
    end

    assign busy         = (state != IDLE);
    assign slave_select = (state == IDLE);
    assign mosi         = (state != IDLE) && tx_shift[DATA_WIDTH-1];

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: a CLK_DIV=4 and a CLK_DIV=2 instance driven together, one observed at a time,
// with a behavioural mode-0 slave and expectations derived from word timing rules.
module tb_spi_master_tx;

    localparam int DW = 8;

    logic          sclk;
    logic          reset;
    logic          start;
    logic [DW-1:0] tx_data;
    logic          miso;

    logic          spi_clk1, mosi1, ss1, busy1, done1;
    logic [DW-1:0] rx1;
    logic          spi_clk2, mosi2, ss2, busy2, done2;
    logic [DW-1:0] rx2;

    spi_master_tx #(.DATA_WIDTH(DW), .CLK_DIV(4)) dut (
        .sclk(sclk), .reset(reset), .start(start), .tx_data(tx_data), .miso(miso),
        .spi_clk(spi_clk1), .mosi(mosi1), .slave_select(ss1), .rx_data(rx1),
        .busy(busy1), .done(done1)
    );

    spi_master_tx #(.DATA_WIDTH(DW), .CLK_DIV(2)) dut2 (
        .sclk(sclk), .reset(reset), .start(start), .tx_data(tx_data), .miso(miso),
        .spi_clk(spi_clk2), .mosi(mosi2), .slave_select(ss2), .rx_data(rx2),
        .busy(busy2), .done(done2)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    logic          sel;
    logic          m_spi_clk, m_mosi, m_ss, m_busy, m_done;
    logic [DW-1:0] m_rx;

    assign m_spi_clk = sel ? spi_clk2 : spi_clk1;
    assign m_mosi    = sel ? mosi2    : mosi1;
    assign m_ss      = sel ? ss2      : ss1;
    assign m_busy    = sel ? busy2    : busy1;
    assign m_done    = sel ? done2    : done1;
    assign m_rx      = sel ? rx2      : rx1;

    // Mode-0 slave: presents the MSB when select falls and the next bit after every falling spi_clk.
    logic          loopback;
    logic [DW-1:0] slv_word;
    logic          slv_bit  = 1'b0;
    logic          prev_ss  = 1'b1;
    logic          prev_clk = 1'b0;
    int            sidx     = 0;

    always @(negedge sclk) begin
        if (prev_ss && !m_ss) begin
            sidx    = DW - 1;
            slv_bit = slv_word[sidx];
        end else if (!m_ss && prev_clk && !m_spi_clk && sidx > 0) begin
            sidx    = sidx - 1;
            slv_bit = slv_word[sidx];
        end
        prev_ss  = m_ss;
        prev_clk = m_spi_clk;
    end

    assign miso = loopback ? m_mosi : slv_bit;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [DW-1:0] tx;
        logic [DW-1:0] slv;
        bit            loop;
        int            div;
        int            inj;
        logic [DW-1:0] exp_rx;
        int            exp_done;
    } vec_t;

    function automatic vec_t mk(input logic [DW-1:0] tx, input logic [DW-1:0] slv,
                                input bit loop, input int div, input int inj);
        vec_t v;
        v.tx       = tx;
        v.slv      = slv;
        v.loop     = loop;
        v.div      = div;
        v.inj      = inj;
        v.exp_rx   = loop ? tx : slv;
        v.exp_done = 1 + (2 * DW + 1) * div;
        return v;
    endfunction

    task automatic run_xfer(input vec_t v);
        int            done_at, busy_n, nrise, first_rise, last_rise, bad_per, ndone, ss_bad, rx_chg;
        logic [DW-1:0] cap, rx_before, rx_at;
        logic          pclk;
        sel      = (v.div == 2);
        loopback = v.loop;
        slv_word = v.slv;
        repeat (80) @(posedge sclk);
        @(negedge sclk);
        tx_data = v.tx;
        start   = 1'b1;
        @(posedge sclk);
        #1;
        start = 1'b0;
        rx_before = m_rx;
        done_at = -1; busy_n = 0; nrise = 0; first_rise = -1; last_rise = 0;
        bad_per = 0; ndone = 0; ss_bad = 0; rx_chg = 0; cap = '0; rx_at = '0; pclk = 1'b0;
        for (int c = 1; c <= v.exp_done + 4; c++) begin
            if (m_spi_clk && !pclk) begin
                nrise++;
                cap = {cap[DW-2:0], m_mosi};
                if (first_rise < 0) first_rise = c;
                else if (c - last_rise != 2 * v.div) bad_per++;
                last_rise = c;
            end
            pclk = m_spi_clk;
            if (m_busy) busy_n++;
            if (m_done) begin
                ndone++;
                if (done_at < 0) begin
                    done_at = c;
                    rx_at   = m_rx;
                end
            end else if (done_at < 0 && m_rx != rx_before) begin
                rx_chg++;
            end
            if (done_at >= 0 && c > done_at && !m_ss) ss_bad++;
            if (v.inj > 0 && c == v.inj) begin
                start   = 1'b1;
                tx_data = 8'h11;
            end
            if (v.inj > 0 && c == v.inj + 1) start = 1'b0;
            @(posedge sclk);
            #1;
        end
        check("done_cycle",      done_at,    v.exp_done);
        check("rx_data",         rx_at,      v.exp_rx);
        check("mosi_bits",       cap,        v.tx);
        check("rising_edges",    nrise,      DW);
        check("first_rise",      first_rise, 1 + v.div);
        check("spi_clk_period",  bad_per,    0);
        check("busy_cycles",     busy_n,     v.exp_done - 1);
        check("done_pulses",     ndone,      1);
        check("ss_after_done",   ss_bad,     0);
        check("rx_stable",       rx_chg,     0);
    endtask

    vec_t vecs[12];

    initial begin
        int            nd, ss_hi, d1, d2;
        logic [DW-1:0] r1, r2;

        vecs[0] = mk(8'hA5, 8'h3C, 1'b0, 4, 0);
        vecs[1] = mk(8'h81, 8'h7E, 1'b0, 2, 0);
        vecs[2] = mk(8'hC3, 8'h00, 1'b1, 4, 0);
        vecs[3] = mk(8'hE7, 8'h42, 1'b0, 4, 20);
        for (int i = 4; i < 12; i++) begin
            vecs[i] = mk(DW'($urandom), DW'($urandom), ($urandom_range(0, 3) == 0),
                         ($urandom_range(0, 1) != 0) ? 4 : 2,
                         ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 30)) : 0);
        end

        reset = 1'b0; start = 1'b0; tx_data = '0; loopback = 1'b0; slv_word = '0; sel = 1'b0;
        repeat (3) @(posedge sclk);
        #1;
        check("reset_ss",      m_ss,      1);
        check("reset_spi_clk", m_spi_clk, 0);
        check("reset_mosi",    m_mosi,    0);
        check("reset_rx",      m_rx,      0);
        check("reset_busy",    m_busy,    0);
        check("reset_done",    m_done,    0);
        reset = 1'b1;

        for (int i = 0; i < 12; i++) run_xfer(vecs[i]);

        // Back-to-back loopback with start held: 0xFF then 0x00, one idle-select cycle between.
        sel = 1'b0;
        loopback = 1'b1;
        repeat (80) @(posedge sclk);
        @(negedge sclk);
        tx_data = 8'hFF;
        start   = 1'b1;
        @(posedge sclk);
        #1;
        tx_data = 8'h00;
        nd = 0; ss_hi = 0; d1 = -1; d2 = -1; r1 = '0; r2 = '0;
        for (int c = 1; c <= 145; c++) begin
            if (m_done) begin
                nd++;
                if (nd == 1) begin d1 = c; r1 = m_rx; end
                if (nd == 2) begin d2 = c; r2 = m_rx; end
            end
            if (c < 138 && m_ss) ss_hi++;
            if (c == 100) start = 1'b0;
            @(posedge sclk);
            #1;
        end
        check("b2b_done_count", nd,    2);
        check("b2b_done1",      d1,    69);
        check("b2b_rx1",        r1,    8'hFF);
        check("b2b_done2",      d2,    138);
        check("b2b_rx2",        r2,    8'h00);
        check("b2b_ss_gap",     ss_hi, 1);
        loopback = 1'b0;

        // Reset asserted in cycle 30 of a transfer aborts it and clears the received word.
        run_xfer(mk(8'h3C, 8'h96, 1'b0, 4, 0));
        sel = 1'b0;
        slv_word = 8'h69;
        repeat (80) @(posedge sclk);
        @(negedge sclk);
        tx_data = 8'hF0;
        start   = 1'b1;
        @(posedge sclk);
        #1;
        start = 1'b0;
        nd = 0;
        for (int c = 1; c <= 30; c++) begin
            if (m_done) nd++;
            if (c < 30) begin
                @(posedge sclk);
                #1;
            end
        end
        reset = 1'b0;
        @(posedge sclk);
        #1;
        check("abort_ss",      m_ss,      1);
        check("abort_spi_clk", m_spi_clk, 0);
        check("abort_mosi",    m_mosi,    0);
        check("abort_busy",    m_busy,    0);
        check("abort_rx",      m_rx,      0);
        reset = 1'b1;
        for (int c = 0; c < 80; c++) begin
            if (m_done) nd++;
            @(posedge sclk);
            #1;
        end
        check("abort_no_done", nd, 0);
        run_xfer(mk(8'h5A, 8'hA7, 1'b0, 4, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
